// File: rtl/note_tone_gen_if.sv
// Note request and tone status bundle between the keyboard stage and the tone generator.
// The master drives the note vector and enable; the slave returns the square wave and status.
interface note_tone_gen_if;
  logic [26:0] note;
  logic        enable;
  logic        audio;
  logic        playing;
  logic [4:0]  note_idx;

  modport master (output note, enable, input audio, playing, note_idx);
  modport slave  (input note, enable, output audio, playing, note_idx);
endinterface

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: the highest requested semitone (bit 0 = A3, 220 Hz) sounds on audio.
// Pitch changes and release are applied only at half-period boundaries, so no runt pulses are produced.
module note_tone_gen #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  note_tone_gen_if.slave       bus
);

  typedef enum logic {IDLE, PLAY} state_t;

  // Equal-tempered ratios 2^(k/12) scaled by 1e9; octaves are applied as shifts of the divisor.
  function automatic logic [63:0] half_period(input int i);
    logic [63:0] ratio;
    logic [63:0] num;
    logic [63:0] den;
    case (i % 12)
      0:       ratio = 64'd1000000000;
      1:       ratio = 64'd1059463094;
      2:       ratio = 64'd1122462048;
      3:       ratio = 64'd1189207115;
      4:       ratio = 64'd1259921050;
      5:       ratio = 64'd1334839854;
      6:       ratio = 64'd1414213562;
      7:       ratio = 64'd1498307077;
      8:       ratio = 64'd1587401052;
      9:       ratio = 64'd1681792831;
      10:      ratio = 64'd1781797436;
      default: ratio = 64'd1887748625;
    endcase
    num = 64'(CLK_HZ) * 64'd1_000_000_000;
    den = (64'd440 * ratio) << (i / 12);
    return (num + den / 64'd2) / den;
  endfunction

  logic [CNT_W-1:0] hp_rom [32];

  for (genvar g = 0; g < 32; g++) begin : g_rom
    if (g < 27) begin : g_entry
      assign hp_rom[g] = CNT_W'(half_period(g) - 64'd1);
    end else begin : g_unused
      assign hp_rom[g] = '0;
    end
  end

  // The lowest note has the longest half-period, so it bounds the counter width.
  if (half_period(0) - 64'd1 >= (64'd1 << CNT_W)) begin : g_hp_overflow
    $error("note_tone_gen: CNT_W too small for the A3 half-period");
  end

  state_t           state, state_n;
  logic [26:0]      note_q;
  logic             en_q;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             audio_r, audio_n;
  logic [4:0]       idx_r, idx_n;
  logic [4:0]       sel;
  logic             any;
  logic             go;

  // Enable is registered alongside the note vector so both share the same two-edge start latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      note_q  <= '0;
      en_q    <= 1'b0;
      cnt     <= '0;
      audio_r <= 1'b0;
      idx_r   <= '0;
    end else begin
      state   <= state_n;
      note_q  <= bus.note;
      en_q    <= bus.enable;
      cnt     <= cnt_n;
      audio_r <= audio_n;
      idx_r   <= idx_n;
    end
  end

  always_comb begin
    sel = '0;
    for (int i = 0; i < 27; i++) begin
      if (note_q[i]) sel = 5'(i);
    end
    any = |note_q;
    go  = en_q & any;
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    audio_n = audio_r;
    idx_n   = idx_r;
    case (state)
      IDLE: begin
        audio_n = 1'b0;
        if (go) begin
          state_n = PLAY;
          idx_n   = sel;
          cnt_n   = hp_rom[sel];
          audio_n = 1'b1;
        end
      end
      PLAY: begin
        if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else if (go) begin
          audio_n = ~audio_r;
          idx_n   = sel;
          cnt_n   = hp_rom[sel];
        end else begin
          audio_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.audio    = audio_r;
  assign bus.playing  = (state == PLAY);
  assign bus.note_idx = idx_r;

endmodule

// File: tb/tb_note_tone_gen.sv
// Self-checking bench for note_tone_gen at CLK_HZ = 1 MHz: measures latencies and half-period
// lengths against a real-arithmetic pitch model, plus table, random and corner-case sequences.
`timescale 1ns/1ps
module tb_note_tone_gen;

  localparam int CLK_HZ = 1_000_000;
  localparam int LIMIT  = 6000;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  note_tone_gen_if bus();

  note_tone_gen #(.CLK_HZ(CLK_HZ), .CNT_W(24)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [26:0] note;
    logic [4:0]  exp_idx;
    int          exp_hp;
  } vec_t;

  function automatic int model_hp(input int i);
    real f;
    f = 220.0 * $pow(2.0, i / 12.0);
    return $rtoi(CLK_HZ / (2.0 * f) + 0.5);
  endfunction

  function automatic int model_idx(input logic [26:0] n);
    int idx;
    idx = 0;
    for (int b = 0; b < 27; b++) if (n[b]) idx = b;
    return idx;
  endfunction

  task automatic applyStimulus(input logic [26:0] n, input logic en);
    bus.note   = n;
    bus.enable = en;
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Counts negedges from the current one while audio stays at level.
  task automatic measure_level(input logic level, output int n);
    n = 0;
    while (bus.audio == level && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_rise(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.audio && lat < 10);
  endtask

  task automatic go_idle(input string tag);
    int n;
    applyStimulus('0, 1'b1);
    n = 0;
    while (bus.playing && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_idle_playing"}, int'(bus.playing), 0);
    checkOutput({tag, "_idle_audio"}, int'(bus.audio), 0);
  endtask

  task automatic play_and_measure(input logic [26:0] n, input int eidx, input int ehp, input string tag);
    int lat, h, l;
    applyStimulus(n, 1'b1);
    wait_rise(lat);
    checkOutput({tag, "_latency"}, lat, 2);
    checkOutput({tag, "_note_idx"}, int'(bus.note_idx), eidx);
    measure_level(1'b1, h);
    checkOutput({tag, "_high"}, h, ehp);
    measure_level(1'b0, l);
    checkOutput({tag, "_low"}, l, ehp);
    go_idle(tag);
  endtask

  vec_t vecs[5];

  initial begin
    int bad, n, lat, h;
    logic [26:0] rn;

    vecs[0] = '{note: 27'h0000001, exp_idx: 5'd0,  exp_hp: 2273};
    vecs[1] = '{note: 27'h0001001, exp_idx: 5'd12, exp_hp: 1136};
    vecs[2] = '{note: 27'h4000000, exp_idx: 5'd26, exp_hp: 506};
    vecs[3] = '{note: 27'h0000300, exp_idx: 5'd9,  exp_hp: 0};
    vecs[4] = '{note: 27'h0480010, exp_idx: 5'd22, exp_hp: 0};

    tests = 0;
    fails = 0;

    // Reset held with every note requested.
    reset = 1'b1;
    applyStimulus(27'h7FFFFFF, 1'b1);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.audio || bus.playing || bus.note_idx != 5'd0) bad++;
    end
    checkOutput("reset_hold_outputs", bad, 0);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_release_edge1_playing", int'(bus.playing), 0);
    @(negedge clk);
    checkOutput("reset_release_edge2_playing", int'(bus.playing), 1);
    checkOutput("reset_release_note_idx", int'(bus.note_idx), 26);
    go_idle("rst");

    for (int v = 0; v < 5; v++) begin
      play_and_measure(vecs[v].note, int'(vecs[v].exp_idx),
                       (vecs[v].exp_hp != 0) ? vecs[v].exp_hp : model_hp(int'(vecs[v].exp_idx)),
                       $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 6; r++) begin
      rn = 27'($urandom) & 27'($urandom);
      if (rn == '0) rn = 27'(1) << $urandom_range(26, 0);
      play_and_measure(rn, model_idx(rn), model_hp(model_idx(rn)), $sformatf("rand%0d", r));
    end

    // Mid-half-period pitch changes are deferred; the last one before the boundary wins.
    applyStimulus(27'h0001001, 1'b1);
    wait_rise(lat);
    measure_level(1'b1, h);
    checkOutput("chg_first_high", h, 1136);
    repeat (100) @(negedge clk);
    applyStimulus(27'h0100000, 1'b1);
    repeat (400) @(negedge clk);
    applyStimulus(27'h4000000, 1'b1);
    measure_level(1'b0, n);
    checkOutput("chg_low_remaining", n, model_hp(12) - 500);
    checkOutput("chg_note_idx", int'(bus.note_idx), 26);
    measure_level(1'b1, h);
    checkOutput("chg_high_after", h, 506);
    measure_level(1'b0, n);
    checkOutput("chg_low_after", n, 506);
    go_idle("chg");

    // Release partway into a high half-period.
    applyStimulus(27'h0001000, 1'b1);
    wait_rise(lat);
    repeat (100) @(negedge clk);
    applyStimulus('0, 1'b1);
    measure_level(1'b1, n);
    checkOutput("rel_high_remaining", n, 1036);
    checkOutput("rel_playing", int'(bus.playing), 0);
    bad = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (bus.audio || bus.playing) bad++;
    end
    checkOutput("rel_quiet", bad, 0);

    // Muted note, then enable.
    applyStimulus(27'h0000020, 1'b0);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.audio || bus.playing) bad++;
    end
    checkOutput("mute_quiet", bad, 0);
    bus.enable = 1'b1;
    wait_rise(lat);
    checkOutput("enable_latency", lat, 2);
    checkOutput("enable_note_idx", int'(bus.note_idx), 5);
    go_idle("en");

    // Asynchronous reset in the middle of a tone, then restart.
    applyStimulus(27'h0000008, 1'b1);
    wait_rise(lat);
    repeat (500) @(negedge clk);
    checkOutput("arst_pre_note_idx", int'(bus.note_idx), 3);
    applyStimulus(27'h0000001, 1'b1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_audio", int'(bus.audio), 0);
    checkOutput("arst_playing", int'(bus.playing), 0);
    checkOutput("arst_note_idx", int'(bus.note_idx), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_rise(lat);
    checkOutput("arst_restart_latency", lat, 2);
    measure_level(1'b1, h);
    checkOutput("arst_restart_high", h, 2273);
    checkOutput("arst_restart_note_idx", int'(bus.note_idx), 0);
    go_idle("arst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
